// File: rtl/sensor_accumulator_pkg.sv
// Shared definitions for the temperature-average front end: FSM states,
// default divider operand width and index-width helper.
package sensor_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned OUT_WIDTH_DEF = 16;

  // Index width for n slots, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sensor_accumulator_if.sv
// Request/result bundle between the sensor scanner and its client.
interface sensor_accumulator_if
  import sensor_accumulator_pkg::*;
#(
  parameter int unsigned NR_SENSORS = 8,
  parameter int unsigned TEMP_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
);

  logic                             start;
  logic [NR_SENSORS*TEMP_WIDTH-1:0] sensors_values;
  logic [NR_SENSORS-1:0]            sensors_en;
  logic                             busy;
  logic                             done;
  logic [OUT_WIDTH-1:0]             sum_out;
  logic [OUT_WIDTH-1:0]             count_out;
  logic                             no_active;
  logic                             overflow;

  modport master (
    output start, sensors_values, sensors_en,
    input  busy, done, sum_out, count_out, no_active, overflow
  );

  modport slave (
    input  start, sensors_values, sensors_en,
    output busy, done, sum_out, count_out, no_active, overflow
  );

endinterface

// File: rtl/sensor_accumulator_sat_adder.sv
// Combinational unsigned saturating adder; clamps to all-ones and flags
// the carry out of the WIDTH-bit result.
module sat_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH:0] w_full;

  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b};
    o_ovf  = w_full[WIDTH];
    o_sum  = w_full[WIDTH] ? '1 : w_full[WIDTH-1:0];
  end

endmodule

// File: rtl/sensor_accumulator.sv
// Snapshots all sensor readings on start, then scans one slot per clock to
// produce the saturating sum and active count for the averaging divider.
module sensor_accumulator
  import sensor_accumulator_pkg::*;
#(
  parameter int unsigned NR_SENSORS = 8,
  parameter int unsigned TEMP_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_accumulator_if.slave  bus
);

  localparam int unsigned IDX_W = clog2_min1(NR_SENSORS);

  state_t                           r_state;
  logic [NR_SENSORS*TEMP_WIDTH-1:0] r_vals;
  logic [NR_SENSORS-1:0]            r_en;
  logic [IDX_W-1:0]                 r_idx;
  logic [OUT_WIDTH-1:0]             r_acc;
  logic [OUT_WIDTH-1:0]             r_cnt;
  logic                             r_ovf;
  logic                             r_busy;
  logic                             r_done;
  logic [OUT_WIDTH-1:0]             r_sum_out;
  logic [OUT_WIDTH-1:0]             r_count_out;
  logic                             r_no_active;
  logic                             r_overflow;

  logic [TEMP_WIDTH-1:0] w_val;
  logic [OUT_WIDTH-1:0]  w_val_ext;
  logic [OUT_WIDTH-1:0]  w_sat_sum;
  logic                  w_sat_ovf;
  logic [OUT_WIDTH-1:0]  w_acc_nxt;
  logic [OUT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_ovf_nxt;
  logic                  w_last;

  always_comb begin
    w_val     = r_vals[r_idx*TEMP_WIDTH +: TEMP_WIDTH];
    w_val_ext = OUT_WIDTH'(w_val);
  end

  // The carry bit of the OUT_WIDTH+1 accumulator lives inside the adder.
  sat_adder #(.WIDTH(OUT_WIDTH)) u_sat_adder (
    .i_a   (r_acc),
    .i_b   (w_val_ext),
    .o_sum (w_sat_sum),
    .o_ovf (w_sat_ovf)
  );

  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (r_en[r_idx]) begin
      w_acc_nxt = w_sat_sum;
      w_cnt_nxt = r_cnt + OUT_WIDTH'(1);
      w_ovf_nxt = r_ovf | w_sat_ovf;
    end
    w_last = (r_idx == IDX_W'(NR_SENSORS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vals      <= '0;
      r_en        <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum_out   <= '0;
      r_count_out <= '0;
      r_no_active <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_vals  <= bus.sensors_values;
            r_en    <= bus.sensors_en;
            r_idx   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          r_ovf <= w_ovf_nxt;
          if (w_last) begin
            r_sum_out   <= w_acc_nxt;
            r_count_out <= w_cnt_nxt;
            r_no_active <= (w_cnt_nxt == '0);
            r_overflow  <= w_ovf_nxt;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum_out   = r_sum_out;
  assign bus.count_out = r_count_out;
  assign bus.no_active = r_no_active;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_sensor_accumulator.sv
// Directed self-checking bench for sensor_accumulator: default 8x8-bit
// instance plus a 12-bit/14-bit-output instance for saturation.
module tb_sensor_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   seen;

  localparam logic [63:0] V_RAMP =
    {8'd27, 8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21, 8'd20};
  localparam logic [95:0] V_MAX12 = {8{12'd4095}};
  localparam logic [95:0] V_RAMP12 =
    {12'd27, 12'd26, 12'd25, 12'd24, 12'd23, 12'd22, 12'd21, 12'd20};

  always #5 clk = ~clk;

  sensor_accumulator_if a ();
  sensor_accumulator_if #(.NR_SENSORS(8), .TEMP_WIDTH(12), .OUT_WIDTH(14)) b ();

  sensor_accumulator u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  sensor_accumulator #(.NR_SENSORS(8), .TEMP_WIDTH(12), .OUT_WIDTH(14)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_a(input logic [63:0] vals, input logic [7:0] en, output int l);
    a.sensors_values = vals;
    a.sensors_en     = en;
    a.start          = 1'b1;
    tick();
    a.start = 1'b0;
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a.done) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic scan_b(input logic [95:0] vals, input logic [7:0] en, output int l);
    b.sensors_values = vals;
    b.sensors_en     = en;
    b.start          = 1'b1;
    tick();
    b.start = 1'b0;
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b.done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    a.start = 1'b0; a.sensors_values = '0; a.sensors_en = '0;
    b.start = 1'b0; b.sensors_values = '0; b.sensors_en = '0;

    // reset state
    tick();
    chk("rst_busy", 32'(a.busy), 0);
    chk("rst_done", 32'(a.done), 0);
    chk("rst_sum", 32'(a.sum_out), 0);
    chk("rst_count", 32'(a.count_out), 0);
    chk("rst_no_active", 32'(a.no_active), 0);
    chk("rst_overflow", 32'(a.overflow), 0);
    rst = 1'b0;
    tick();

    // T2 basic full mask
    scan_a(V_RAMP, 8'hFF, lat);
    chk("t2_latency", 32'(lat), 8);
    chk("t2_sum", 32'(a.sum_out), 188);
    chk("t2_count", 32'(a.count_out), 8);
    chk("t2_no_active", 32'(a.no_active), 0);
    chk("t2_overflow", 32'(a.overflow), 0);
    chk("t2_busy_in_done", 32'(a.busy), 1);
    tick();
    chk("t2_done_one_cycle", 32'(a.done), 0);
    chk("t2_busy_idle", 32'(a.busy), 0);
    chk("t2_sum_held", 32'(a.sum_out), 188);

    // T3 partial mask
    scan_a(V_RAMP, 8'b1010_0101, lat);
    chk("t3_latency", 32'(lat), 8);
    chk("t3_sum", 32'(a.sum_out), 94);
    chk("t3_count", 32'(a.count_out), 4);
    tick();

    // T1 asynchronous reset with idx = 3
    a.sensors_values = V_RAMP;
    a.sensors_en     = 8'hFF;
    a.start          = 1'b1;
    tick();
    a.start = 1'b0;
    tick(); tick(); tick();
    chk("t1_busy_before", 32'(a.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_busy", 32'(a.busy), 0);
    chk("t1_done", 32'(a.done), 0);
    chk("t1_sum", 32'(a.sum_out), 0);
    chk("t1_count", 32'(a.count_out), 0);
    chk("t1_no_active", 32'(a.no_active), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a.done) seen++;
    end
    chk("t1_no_done_after", 32'(seen), 0);
    scan_a(V_RAMP, 8'hFF, lat);
    chk("t1_rescan_latency", 32'(lat), 8);
    chk("t1_rescan_sum", 32'(a.sum_out), 188);
    tick();

    // T4 empty mask
    scan_a(V_RAMP, 8'h00, lat);
    chk("t4_latency", 32'(lat), 8);
    chk("t4_sum", 32'(a.sum_out), 0);
    chk("t4_count", 32'(a.count_out), 0);
    chk("t4_no_active", 32'(a.no_active), 1);
    tick();

    // T5 snapshot isolation and ignored start
    a.sensors_values = V_RAMP;
    a.sensors_en     = 8'b1010_0101;
    a.start          = 1'b1;
    tick();
    seen = 0;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      a.sensors_values = {$urandom, $urandom};
      a.sensors_en     = 8'($urandom);
      a.start          = ~a.start;
      tick();
      if (a.done) begin
        seen++;
        lat = i;
        break;
      end
    end
    chk("t5_latency", 32'(lat), 8);
    chk("t5_done_count", 32'(seen), 1);
    chk("t5_sum", 32'(a.sum_out), 94);
    chk("t5_count", 32'(a.count_out), 4);
    a.sensors_values = V_RAMP;
    a.sensors_en     = 8'hFF;
    a.start          = 1'b1;
    tick();
    chk("t5_start_in_done_ignored", 32'(a.busy), 0);
    chk("t5_done_cleared", 32'(a.done), 0);
    tick();
    chk("t5_start_after_done_accepted", 32'(a.busy), 1);
    a.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a.done) begin
        lat = i;
        break;
      end
    end
    chk("t5_next_latency", 32'(lat), 8);
    chk("t5_next_sum", 32'(a.sum_out), 188);
    tick();

    // T6 saturation on 12-bit readings, 14-bit outputs
    scan_b(V_MAX12, 8'hFF, lat);
    chk("t6_latency", 32'(lat), 8);
    chk("t6_sum_sat", 32'(b.sum_out), 16383);
    chk("t6_overflow", 32'(b.overflow), 1);
    chk("t6_count", 32'(b.count_out), 8);
    tick();
    chk("t6_overflow_held", 32'(b.overflow), 1);
    scan_b(V_RAMP12, 8'hFF, lat);
    chk("t6_clear_sum", 32'(b.sum_out), 188);
    chk("t6_clear_overflow", 32'(b.overflow), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
